// File: rtl/axi_mem_slave_model.sv
// axi_mem_slave_model: single-outstanding AXI-style memory slave with byte-strobed writes, registered reads and LFSR stalls
module axi_mem_slave_model #(
    parameter int          WIDTH    = 32,
    parameter int          DEPTH    = 4096,
    parameter int          STALL_EN = 1,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic             axi_clk,
    input  logic             rst,
    input  logic [7:0]       aid,
    input  logic [31:0]      aaddr,
    input  logic [7:0]       alen,
    input  logic [2:0]       asize,
    input  logic [1:0]       aburst,
    input  logic [1:0]       alock,
    input  logic             avalid,
    output logic             aready,
    input  logic             atype,
    input  logic [7:0]       wid,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH/8-1:0] wstrb,
    input  logic             wlast,
    input  logic             wvalid,
    output logic             wready,
    output logic [7:0]       bid,
    output logic [1:0]       bresp,
    output logic             bvalid,
    input  logic             bready,
    output logic [7:0]       rid,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       rresp,
    output logic             rlast,
    output logic             rvalid,
    input  logic             rready,
    output logic             proto_err
);
    localparam int NB = WIDTH / 8;
    localparam int SB = $clog2(NB);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    state_t           state, nstate;
    logic [15:0]      lfsr, lfsr_n;
    logic             stall_n;
    logic [AW-1:0]    idx, idx_n;
    logic [7:0]       beat, beat_n, len, len_n, id;
    logic             fixed;
    logic             a_hs, w_hs, b_hs, r_hs, err, load;
    logic             aready_d, wready_d, bvalid_d, rvalid_d, rlast_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             unused_ok;

    assign a_hs      = (state == IDLE) & avalid & aready;
    assign w_hs      = (state == WDATA) & wvalid & wready;
    assign b_hs      = (state == WRESP) & bvalid & bready;
    assign r_hs      = (state == RDATA) & rvalid & rready;
    assign lfsr_n    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign stall_n   = (STALL_EN != 0) & lfsr_n[0];
    assign bid       = id;
    assign rid       = id;
    assign bresp     = 2'b00;
    assign rresp     = 2'b00;
    assign unused_ok = ^{alock, wid, aaddr};

    // State register
    always_ff @(posedge axi_clk)
        state <= rst ? IDLE : nstate;

    // Next-state: one transaction at a time, write bursts end on the counted beat
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    nstate = a_hs ? (atype ? WDATA : RDATA) : IDLE;
            WDATA:   nstate = (w_hs & (beat == len)) ? WRESP : WDATA;
            WRESP:   nstate = b_hs ? IDLE : WRESP;
            default: nstate = (r_hs & rlast) ? IDLE : RDATA;
        endcase
    end

    // Next-cycle values of the burst counters and registered outputs; stalls use next cycle's LFSR bit
    always_comb begin
        idx_n    = a_hs ? aaddr[AW+SB-1:SB] : ((w_hs | r_hs) & ~fixed) ? idx + 1'b1 : idx;
        beat_n   = a_hs ? 8'd0 : (w_hs | r_hs) ? beat + 8'd1 : beat;
        len_n    = a_hs ? alen : len;
        err      = (a_hs & ((asize != 3'(SB)) | aburst[1])) | (w_hs & (wlast ^ (beat == len)));
        load     = (nstate == RDATA) & (~rvalid | rready);
        aready_d = (nstate == IDLE) & ~stall_n;
        wready_d = (nstate == WDATA) & ~stall_n;
        bvalid_d = nstate == WRESP;
        rvalid_d = (nstate == RDATA) & ((rvalid & ~rready) | ~stall_n);
        rlast_d  = (nstate == RDATA) & (load ? (beat_n == len_n) : rlast);
    end

    // Burst context, LFSR, sticky error and registered outputs; a pending read beat is never reloaded
    always_ff @(posedge axi_clk) begin
        if (rst) begin
            lfsr      <= SEED;
            idx       <= '0;
            beat      <= '0;
            len       <= '0;
            id        <= '0;
            fixed     <= 1'b0;
            aready    <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            rvalid    <= 1'b0;
            rlast     <= 1'b0;
            rdata     <= '0;
            proto_err <= 1'b0;
        end else begin
            lfsr      <= lfsr_n;
            idx       <= idx_n;
            beat      <= beat_n;
            len       <= len_n;
            id        <= a_hs ? aid : id;
            fixed     <= a_hs ? (aburst == 2'b00) : fixed;
            aready    <= aready_d;
            wready    <= wready_d;
            bvalid    <= bvalid_d;
            rvalid    <= rvalid_d;
            rlast     <= rlast_d;
            rdata     <= load ? mem[idx_n] : rdata;
            proto_err <= proto_err | err;
        end
    end

    // Byte-strobed write port; contents survive reset
    always_ff @(posedge axi_clk)
        for (int b = 0; b < NB; b++)
            if (w_hs & ~rst & wstrb[b])
                mem[idx][8*b +: 8] <= wdata[8*b +: 8];
endmodule

// File: tb/tb_axi_mem_slave_model.sv
// tb_axi_mem_slave_model: directed checks on a stall-free 16-word instance and a stalling 4096-word instance
module tb_axi_mem_slave_model;
    localparam int TMO = 500;

    logic axi_clk = 1'b0, rst = 1'b1, sel = 1'b0;
    always #5 axi_clk = ~axi_clk;

    logic [7:0]  aid = '0, alen = '0;
    logic [31:0] aaddr = '0, wdata = '0;
    logic [2:0]  asize = 3'd2;
    logic [1:0]  aburst = 2'b01;
    logic [3:0]  wstrb = '0;
    logic        atype = 1'b0, avalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0, rready = 1'b0;

    logic [1:0]  ar_v, wrdy_v, bv_v, rv_v, rl_v, pe_v;
    logic [7:0]  bid_v [2], rid_v [2];
    logic [1:0]  bresp_v [2], rresp_v [2];
    logic [31:0] rdata_v [2];

    logic        aready, wready, bvalid, rvalid, rlast, proto_err;
    logic [7:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    assign aready    = ar_v[sel];
    assign wready    = wrdy_v[sel];
    assign bvalid    = bv_v[sel];
    assign rvalid    = rv_v[sel];
    assign rlast     = rl_v[sel];
    assign proto_err = pe_v[sel];
    assign bid       = bid_v[sel];
    assign rid       = rid_v[sel];
    assign bresp     = bresp_v[sel];
    assign rresp     = rresp_v[sel];
    assign rdata     = rdata_v[sel];

    for (genvar i = 0; i < 2; i++) begin : g_dut
        axi_mem_slave_model #(
            .WIDTH(32), .DEPTH(i ? 4096 : 16), .STALL_EN(i), .SEED(16'hACE1)
        ) dut (
            .axi_clk(axi_clk), .rst(rst),
            .aid(aid), .aaddr(aaddr), .alen(alen), .asize(asize), .aburst(aburst), .alock(2'b10),
            .avalid(avalid & (sel == 1'(i))), .aready(ar_v[i]), .atype(atype),
            .wid(8'hEE), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
            .wvalid(wvalid & (sel == 1'(i))), .wready(wrdy_v[i]),
            .bid(bid_v[i]), .bresp(bresp_v[i]), .bvalid(bv_v[i]), .bready(bready & (sel == 1'(i))),
            .rid(rid_v[i]), .rdata(rdata_v[i]), .rresp(rresp_v[i]), .rlast(rl_v[i]), .rvalid(rv_v[i]),
            .rready(rready & (sel == 1'(i))), .proto_err(pe_v[i])
        );
    end

    int          cyc = 0, n_cmp = 0, n_bad = 0, hold_bad = 0;
    int          last_k, nlast, id_bad, t_first, t_end, bad;
    logic [31:0] wd [256];
    logic [31:0] got [$];
    logic [7:0]  got_bid;
    logic        pend_r = 1'b0, pend_b = 1'b0, hold_l = 1'b0;
    logic [31:0] hold_d = '0;

    always @(posedge axi_clk) cyc <= cyc + 1;

    // A stalled R beat must keep valid/data/last; a pending B must keep valid
    always @(negedge axi_clk) begin
        if (pend_r && (!rvalid || rdata != hold_d || rlast != hold_l)) hold_bad++;
        if (pend_b && !bvalid) hold_bad++;
        pend_r = rvalid && !rready && !rst;
        pend_b = bvalid && !bready && !rst;
        hold_d = rdata;
        hold_l = rlast;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int w);
        return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge axi_clk); #1;
        rst = 1'b0;
    endtask

    task automatic do_addr(input logic t, input logic [31:0] a, input logic [7:0] l,
                           input logic [1:0] bu, input logic [2:0] sz, input logic [7:0] id);
        int n = 0;
        atype = t; aaddr = a; alen = l; aburst = bu; asize = sz; aid = id; avalid = 1'b1;
        @(negedge axi_clk);
        while (!aready && n < TMO) begin @(negedge axi_clk); n++; end
        if (n >= TMO) check("a_timeout", 64'(n), 0);
        @(posedge axi_clk); #1;
        avalid = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu, input logic [2:0] sz,
                      input logic [7:0] id, input logic [3:0] st, input int early, input logic rnd);
        int n;
        do_addr(1'b1, a, l, bu, sz, id);
        if (!rnd) check("w_rdy_lat", wready, 1);
        for (int k = 0; k <= int'(l); k++) begin
            wdata = wd[k]; wstrb = st; wlast = (k == int'(l)) || (k == early); wvalid = 1'b1; n = 0;
            @(negedge axi_clk);
            while (!wready && n < TMO) begin @(negedge axi_clk); n++; end
            if (n >= TMO) check("w_timeout", 64'(n), 0);
            @(posedge axi_clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (!rnd) check("b_lat", bvalid, 1);
        bready = rnd ? 1'($urandom_range(1)) : 1'b1; n = 0;
        @(negedge axi_clk);
        while (!(bvalid && bready) && n < TMO) begin
            @(posedge axi_clk); #1;
            bready = rnd ? 1'($urandom_range(1)) : 1'b1;
            @(negedge axi_clk); n++;
        end
        if (n >= TMO) check("b_timeout", 64'(n), 0);
        got_bid = bid;
        check("bresp", bresp, 0);
        @(posedge axi_clk); #1;
        bready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu,
                      input logic [7:0] id, input logic rnd);
        int n;
        got.delete(); last_k = -1; nlast = 0; id_bad = 0;
        do_addr(1'b0, a, l, bu, 3'd2, id);
        t_first = cyc;
        if (!rnd) check("r_lat", rvalid, 1);
        for (int k = 0; k <= int'(l); k++) begin
            rready = rnd ? 1'($urandom_range(1)) : 1'b1; n = 0;
            @(negedge axi_clk);
            while (!(rvalid && rready) && n < TMO) begin
                @(posedge axi_clk); #1;
                rready = rnd ? 1'($urandom_range(1)) : 1'b1;
                @(negedge axi_clk); n++;
            end
            if (n >= TMO) check("r_timeout", 64'(n), 0);
            got.push_back(rdata);
            if (rlast) begin nlast++; last_k = k; end
            if (rid != id) id_bad++;
            @(posedge axi_clk); #1;
        end
        rready = 1'b0;
        t_end = cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge axi_clk);
        #1;
        check("rst_ctl", {ar_v, wrdy_v, bv_v, rv_v, rl_v, pe_v}, 0);
        check("rst_rdata", {rdata_v[0], rdata_v[1]}, 0);
        check("rst_ids", {bid_v[0], bid_v[1], rid_v[0], rid_v[1], bresp_v[0], rresp_v[0]}, 0);
        rst = 1'b0;

        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        wr(32'h0, 8'd3, 2'b01, 3'd2, 8'h5A, 4'hF, -1, 1'b0);
        check("basic_bid", got_bid, 8'h5A);
        rd(32'h0, 8'd3, 2'b01, 8'h5A, 1'b0);
        check("basic_data", {got[0][7:0], got[1][7:0], got[2][7:0], got[3][7:0]}, 32'h11223344);
        check("basic_last", {8'(nlast), 8'(last_k)}, 16'h0103);
        check("basic_rid", 64'(id_bad), 0);
        check("basic_rresp", rresp, 0);
        check("basic_perr", proto_err, 0);

        wd[0] = 32'hAABBCCDD;
        wr(32'd20, 8'd0, 2'b01, 3'd2, 8'h01, 4'hF, -1, 1'b0);
        wd[0] = 32'h11223344;
        wr(32'd20, 8'd0, 2'b01, 3'd2, 8'h02, 4'b0101, -1, 1'b0);
        rd(32'd20, 8'd0, 2'b01, 8'h03, 1'b0);
        check("strobe", got[0], 32'hAA22CC44);

        wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
        wr(32'd56, 8'd3, 2'b01, 3'd2, 8'h10, 4'hF, -1, 1'b0);
        rd(32'd56, 8'd3, 2'b01, 8'h11, 1'b0);
        check("wrap_rd", {got[0][7:0], got[1][7:0], got[2][7:0], got[3][7:0]}, 32'hA0A1A2A3);
        rd(32'd0, 8'd1, 2'b01, 8'h12, 1'b0);
        check("wrap_w0w1", {got[0], got[1]}, {32'hA2, 32'hA3});

        wd[0] = 32'hB0; wd[1] = 32'hB1; wd[2] = 32'hB2;
        wr(32'd32, 8'd2, 2'b00, 3'd2, 8'h13, 4'hF, -1, 1'b0);
        rd(32'd32, 8'd2, 2'b00, 8'h14, 1'b0);
        check("fixed", {got[0][7:0], got[1][7:0], got[2][7:0]}, 24'hB2B2B2);
        check("fixed_perr", proto_err, 0);

        wd[0] = 32'hC0; wd[1] = 32'hC1; wd[2] = 32'hC2; wd[3] = 32'hC3;
        wr(32'd40, 8'd3, 2'b01, 3'd2, 8'h21, 4'hF, 1, 1'b0);
        check("perr_wlast", proto_err, 1);
        check("perr_wlast_bid", got_bid, 8'h21);
        rd(32'd40, 8'd3, 2'b01, 8'h22, 1'b0);
        check("perr_wlast_data", {got[0][7:0], got[1][7:0], got[2][7:0], got[3][7:0]}, 32'hC0C1C2C3);
        check("perr_hold", proto_err, 1);
        pulse_rst();
        check("perr_clear", proto_err, 0);
        wd[0] = 32'hD0;
        wr(32'd48, 8'd0, 2'b01, 3'd3, 8'h23, 4'hF, -1, 1'b0);
        check("perr_size", proto_err, 1);
        rd(32'd48, 8'd0, 2'b01, 8'h24, 1'b0);
        check("perr_size_data", got[0], 32'hD0);
        pulse_rst();
        wd[0] = 32'hE0; wd[1] = 32'hE1;
        wr(32'd44, 8'd1, 2'b11, 3'd2, 8'h25, 4'hF, -1, 1'b0);
        check("perr_burst", proto_err, 1);
        rd(32'd44, 8'd1, 2'b01, 8'h26, 1'b0);
        check("perr_burst_data", {got[0], got[1]}, {32'hE0, 32'hE1});
        pulse_rst();

        rd(32'h0, 8'd69, 2'b01, 8'h46, 1'b0);
        check("rd70_cycles", 64'(t_end - t_first), 70);
        check("rd70_last", {8'(nlast), 8'(last_k)}, 16'h0145);
        check("rd70_rid", 64'(id_bad), 0);
        check("rd70_wrap", {got[0], got[16]}, {32'hA2, 32'hA2});

        do_addr(1'b0, 32'h0, 8'd15, 2'b01, 3'd2, 8'h77);
        rready = 1'b1;
        repeat (10) begin @(posedge axi_clk); #1; end
        check("mid_beat10", {rvalid, rdata}, {1'b1, 32'hC0});
        rst = 1'b1;
        @(posedge axi_clk); #1;
        check("mid_rst_ctl", {aready, wready, bvalid, rvalid, rlast, proto_err}, 0);
        check("mid_rst_val", {rdata, rid, bid}, 0);
        rst = 1'b0; rready = 1'b0;
        rd(32'd56, 8'd3, 2'b01, 8'h78, 1'b0);
        check("mid_after", {got[0][7:0], got[1][7:0], got[2][7:0], got[3][7:0]}, 32'hA0A1A2A3);
        check("mid_after_rid", 64'(id_bad), 0);

        sel = 1'b1;
        for (int b = 0; b <= 'h800; b += 280) begin
            for (int k = 0; k < 70; k++) wd[k] = pat(b / 4 + k);
            wr(32'(b), 8'd69, 2'b01, 3'd2, 8'(b / 280 + 8'h80), 4'hF, -1, 1'b1);
            check("sweep_bid", got_bid, 8'(b / 280 + 8'h80));
        end
        for (int b = 0; b <= 'h800; b += 280) begin
            rd(32'(b), 8'd69, 2'b01, 8'(b / 280 + 8'h90), 1'b1);
            bad = 0;
            for (int k = 0; k < 70; k++) if (got[k] != pat(b / 4 + k)) bad++;
            check("sweep_data", 64'(bad), 0);
            check("sweep_last", {8'(nlast), 8'(last_k), 8'(id_bad)}, 24'h014500);
        end
        check("sweep_perr", proto_err, 0);
        check("hold_rules", 64'(hold_bad), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
